// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the APB request arbiter.
// States are one-hot; CNT_W sizes the saturating wait counter.
package apb_ctrl_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    localparam logic RW_READ = 1'b1;

    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_ISSUE = 3'b010;
    localparam logic [2:0] ST_RESP  = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_RESP  = ST_RESP
    } state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/apb_req_arbiter_rr_arb2.sv
// Two-way round-robin picker: gnt_id is the combinational winner,
// last grant is registered on accept. Ports: clk, rst, valid, accept, gnt_id, any_valid.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic       gnt_id,
    output logic       any_valid
);

    logic last_q;
    logic last_d;

    always_comb begin
        any_valid = |valid;
        // on a tie the requester not served last time wins
        gnt_id    = (valid == 2'b11) ? ~last_q : valid[1];
        last_d    = accept ? gnt_id : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Two-requester arbiter/sequencer in front of master_bridge: one APB transfer per grant.
// Ports: reqN_* commands in, respN_* responses out, bridge drive out, bridge status in.
module apb_req_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              resp0_valid,
    output logic              resp0_err,
    output logic [DATA_W-1:0] resp0_rdata,
    output logic              resp1_valid,
    output logic              resp1_err,
    output logic [DATA_W-1:0] resp1_rdata,
    output logic              transfer,
    output logic              READ_WRITE,
    output logic [ADDR_W-1:0] apb_write_paddr,
    output logic [ADDR_W-1:0] apb_read_paddr,
    output logic [DATA_W-1:0] apb_write_data,
    input  logic              PENABLE,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [DATA_W-1:0] apb_read_data_out
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    state_e state_q, state_d;
    cmd_t   cmd_q, cmd_d, cmd_new;
    logic   gnt_q, gnt_d;

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    logic [1:0] ready_q, ready_d;
    logic [1:0] rvalid_q, rvalid_d;
    logic [1:0] rerr_q, rerr_d;

    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

    logic              xfer_q, xfer_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] wpaddr_q, wpaddr_d;
    logic [ADDR_W-1:0] rpaddr_q, rpaddr_d;
    logic [DATA_W-1:0] wdo_q, wdo_d;

    logic              arb_gnt, arb_any, arb_accept;
    logic              done, err;
    logic [DATA_W-1:0] rd;

    rr_arb2 u_arb (
        .clk       (PCLK),
        .rst       (PRESET),
        .valid     ({req1_valid, req0_valid}),
        .accept    (arb_accept),
        .gnt_id    (arb_gnt),
        .any_valid (arb_any)
    );

    always_comb begin
        cmd_new.write = arb_gnt ? req1_write : req0_write;
        cmd_new.addr  = arb_gnt ? req1_addr  : req0_addr;
        cmd_new.wdata = arb_gnt ? req1_wdata : req0_wdata;
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        cnt_inc    = sat_inc(cnt_q);
        ready_d    = '0;
        rvalid_d   = '0;
        rerr_d     = '0;
        rdata_d    = '0;
        arb_accept = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        rd         = '0;

        unique case (1'b1)
            state_q[0]: begin
                if (arb_any) begin
                    arb_accept       = 1'b1;
                    ready_d[arb_gnt] = 1'b1;
                    cmd_d            = cmd_new;
                    gnt_d            = arb_gnt;
                    cnt_d            = '0;
                    state_d          = S_ISSUE;
                end
            end
            state_q[1]: begin
                cnt_d = cnt_inc;
                // slave error beats completion, completion beats timeout
                if (PSLVERR) begin
                    done = 1'b1;
                    err  = 1'b1;
                end else if (PENABLE && PREADY) begin
                    done = 1'b1;
                    rd   = cmd_q.write ? '0 : apb_read_data_out;
                end else if (cnt_inc >= TMO) begin
                    done = 1'b1;
                    err  = 1'b1;
                end
                if (done) begin
                    state_d         = S_RESP;
                    rvalid_d[gnt_q] = 1'b1;
                    rerr_d[gnt_q]   = err;
                    rdata_d[gnt_q]  = rd;
                end
            end
            state_q[2]: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // bridge drive is registered, so it follows the next state
        xfer_d   = (state_d == S_ISSUE);
        rw_d     = 1'b0;
        wpaddr_d = '0;
        rpaddr_d = '0;
        wdo_d    = '0;
        if (xfer_d) begin
            if (cmd_d.write) begin
                wpaddr_d = cmd_d.addr;
                wdo_d    = cmd_d.wdata;
            end else begin
                rw_d     = RW_READ;
                rpaddr_d = cmd_d.addr;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= S_IDLE;
            cmd_q    <= '0;
            gnt_q    <= 1'b0;
            cnt_q    <= '0;
            ready_q  <= '0;
            rvalid_q <= '0;
            rerr_q   <= '0;
            rdata_q  <= '0;
            xfer_q   <= 1'b0;
            rw_q     <= 1'b0;
            wpaddr_q <= '0;
            rpaddr_q <= '0;
            wdo_q    <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
            xfer_q   <= xfer_d;
            rw_q     <= rw_d;
            wpaddr_q <= wpaddr_d;
            rpaddr_q <= rpaddr_d;
            wdo_q    <= wdo_d;
        end
    end

    assign req0_ready      = ready_q[0];
    assign req1_ready      = ready_q[1];
    assign resp0_valid     = rvalid_q[0];
    assign resp1_valid     = rvalid_q[1];
    assign resp0_err       = rerr_q[0];
    assign resp1_err       = rerr_q[1];
    assign resp0_rdata     = rdata_q[0];
    assign resp1_rdata     = rdata_q[1];
    assign transfer        = xfer_q;
    assign READ_WRITE      = rw_q;
    assign apb_write_paddr = wpaddr_q;
    assign apb_read_paddr  = rpaddr_q;
    assign apb_write_data  = wdo_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: bridge/slave behaviour is emulated here,
// expectations come from a round-robin and response model.
module tb_apb_req_arbiter;

    localparam int TMO = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       v0, w0, v1, w1;
    logic [8:0] a0, a1;
    logic [7:0] d0, d1;
    logic       r0, r1, rv0, rv1, re0, re1;
    logic [7:0] rd0, rd1;
    logic       tr, rw;
    logic [8:0] wpa, rpa;
    logic [7:0] wdo;
    logic       pen, prdy, perr;
    logic [7:0] prd;

    int         p_wait, p_err_at;
    bit         p_hang;
    logic [7:0] p_data;
    int         icnt = 0;

    int n_chk = 0;
    int n_fail = 0;
    int last_g;

    int          win, k, aw;
    bit          got, e, oth, stab, gap;
    logic [7:0]  rdv;
    logic [26:0] br;

    apb_req_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .PCLK              (clk),
        .PRESET            (rst),
        .req0_valid        (v0),
        .req0_write        (w0),
        .req0_addr         (a0),
        .req0_wdata        (d0),
        .req0_ready        (r0),
        .req1_valid        (v1),
        .req1_write        (w1),
        .req1_addr         (a1),
        .req1_wdata        (d1),
        .req1_ready        (r1),
        .resp0_valid       (rv0),
        .resp0_err         (re0),
        .resp0_rdata       (rd0),
        .resp1_valid       (rv1),
        .resp1_err         (re1),
        .resp1_rdata       (rd1),
        .transfer          (tr),
        .READ_WRITE        (rw),
        .apb_write_paddr   (wpa),
        .apb_read_paddr    (rpa),
        .apb_write_data    (wdo),
        .PENABLE           (pen),
        .PREADY            (prdy),
        .PSLVERR           (perr),
        .apb_read_data_out (prd)
    );

    // bridge + slave: SETUP in ISSUE cycle 1, ENABLE from cycle 2,
    // PREADY after p_wait wait states, PSLVERR in cycle p_err_at
    always @(negedge clk) begin
        if (tr) icnt = icnt + 1;
        else icnt = 0;
        pen  = tr && icnt >= 2;
        prdy = tr && !p_hang && icnt >= 2 + p_wait;
        perr = tr && p_err_at != 0 && icnt == p_err_at;
        prd  = p_data;
    end

    function automatic int rr_pick(bit a, bit b, int last);
        if (a && b) return (last == 1) ? 0 : 1;
        return b ? 1 : 0;
    endfunction

    function automatic logic [26:0] exp_br(bit wr, logic [8:0] a,
                                           logic [7:0] d);
        if (wr) return {1'b0, a, 9'h000, d};
        return {1'b1, 9'h000, a, 8'h00};
    endfunction

    // ISSUE cycle count and response from the priority rules
    task automatic ref_txn(input bit wr, input int wt, input int ea,
                           input bit hang, input logic [7:0] sd,
                           output int ek, output bit ee,
                           output logic [7:0] erd);
        ek = 0; ee = 1'b0; erd = 8'h00;
        for (int i = 1; i <= 300; i++) begin
            if (ea == i) begin
                ek = i; ee = 1'b1; return;
            end
            if (!hang && i >= 2 && i >= 2 + wt) begin
                ek = i; erd = wr ? 8'h00 : sd; return;
            end
            if (i >= TMO) begin
                ek = i; ee = 1'b1; return;
            end
        end
    endtask

    // drives one grant through to its response and records observations
    task automatic do_txn(input bit keep);
        win = -1; k = 0; got = 0; e = 0; rdv = 0;
        oth = 0; stab = 1; gap = 0; br = '0; aw = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            aw++;
            if (r0 || r1) begin
                win = (r0 && r1) ? 2 : (r1 ? 1 : 0);
                break;
            end
        end
        if (win < 0 || win == 2) return;
        br = {rw, wpa, rpa, wdo};
        if (win == 0) begin
            w0 = 1'($urandom); a0 = 9'($urandom); d0 = 8'($urandom);
            v0 = keep;
        end else begin
            w1 = 1'($urandom); a1 = 9'($urandom); d1 = 8'($urandom);
            v1 = keep;
        end
        for (int i = 0; i < 300; i++) begin
            if (!tr) break;
            k++;
            if ({rw, wpa, rpa, wdo} !== br || rv0 || rv1) stab = 0;
            if (k > 1 && (r0 || r1)) stab = 0;
            @(negedge clk);
        end
        if (r0 || r1) stab = 0;
        got = (win == 1) ? rv1 : rv0;
        oth = (win == 1) ? rv0 : rv1;
        e   = (win == 1) ? re1 : re0;
        rdv = (win == 1) ? rd1 : rd0;
        @(negedge clk);
        gap = !tr && !r0 && !r1 && !rv0 && !rv1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({r0, r1, rv0, rv1, re0, re1, rd0, rd1, tr, rw, wpa, rpa, wdo}
            !== '0) begin
            n_fail++;
            $display("FAIL reset_outs got %h exp 0",
                     {r0, r1, rv0, rv1, re0, re1, rd0, rd1,
                      tr, rw, wpa, rpa, wdo});
        end
        rst = 1'b0;
        last_g = 1;
    endtask

    task automatic test_write();
        int ek; bit ee; logic [7:0] erd;
        v0 = 1; w0 = 1; a0 = 9'h005; d0 = 8'hA5; v1 = 0;
        p_wait = 0; p_err_at = 0; p_hang = 0; p_data = 8'h77;
        ref_txn(1, 0, 0, 0, 8'h77, ek, ee, erd);
        do_txn(0);
        last_g = 0;
        n_chk++;
        if (win !== 0) begin
            n_fail++; $display("FAIL wr_win got %0d exp 0", win);
        end
        n_chk++;
        if (k !== ek) begin
            n_fail++; $display("FAIL wr_k got %0d exp %0d", k, ek);
        end
        n_chk++;
        if ({got, e, rdv} !== {1'b1, ee, erd}) begin
            n_fail++;
            $display("FAIL wr_resp got %b/%b/%h exp 1/%b/%h",
                     got, e, rdv, ee, erd);
        end
        n_chk++;
        if (br !== exp_br(1, 9'h005, 8'hA5)) begin
            n_fail++;
            $display("FAIL wr_bridge got %h exp %h",
                     br, exp_br(1, 9'h005, 8'hA5));
        end
        n_chk++;
        if ({stab, gap, oth, aw == 1} !== 4'b1101) begin
            n_fail++;
            $display("FAIL wr_proto got %b exp 1101",
                     {stab, gap, oth, aw == 1});
        end
    endtask

    task automatic test_read_wait();
        int ek; bit ee; logic [7:0] erd;
        v1 = 1; w1 = 0; a1 = 9'h10C; d1 = 8'hEE; v0 = 0;
        p_wait = 3; p_err_at = 0; p_hang = 0; p_data = 8'h3C;
        ref_txn(0, 3, 0, 0, 8'h3C, ek, ee, erd);
        do_txn(0);
        last_g = 1;
        n_chk++;
        if (win !== 1) begin
            n_fail++; $display("FAIL rd_win got %0d exp 1", win);
        end
        n_chk++;
        if (k !== ek) begin
            n_fail++; $display("FAIL rd_k got %0d exp %0d", k, ek);
        end
        n_chk++;
        if ({got, e, rdv} !== {1'b1, ee, erd}) begin
            n_fail++;
            $display("FAIL rd_resp got %b/%b/%h exp 1/%b/%h",
                     got, e, rdv, ee, erd);
        end
        n_chk++;
        if (br !== exp_br(0, 9'h10C, 8'hEE)) begin
            n_fail++;
            $display("FAIL rd_bridge got %h exp %h",
                     br, exp_br(0, 9'h10C, 8'hEE));
        end
        n_chk++;
        if ({stab, gap, oth, aw == 1} !== 4'b1101) begin
            n_fail++;
            $display("FAIL rd_proto got %b exp 1101",
                     {stab, gap, oth, aw == 1});
        end
    endtask

    task automatic test_rr_tie();
        int ek, ew; bit ee; logic [7:0] erd;
        bit cw; logic [8:0] ca; logic [7:0] cd;
        v0 = 1; w0 = 1; a0 = 9'h021; d0 = 8'h10;
        v1 = 1; w1 = 0; a1 = 9'h131; d1 = 8'h20;
        p_err_at = 0; p_hang = 0;
        for (int n = 0; n < 6; n++) begin
            p_wait = n % 2; p_data = 8'($urandom);
            ew = rr_pick(v0, v1, last_g);
            cw = ew ? w1 : w0; ca = ew ? a1 : a0; cd = ew ? d1 : d0;
            ref_txn(cw, p_wait, 0, 0, p_data, ek, ee, erd);
            do_txn(1);
            last_g = ew;
            n_chk++;
            if (win !== ew) begin
                n_fail++;
                $display("FAIL rr_win[%0d] got %0d exp %0d", n, win, ew);
            end
            n_chk++;
            if ({k == ek, got, e, rdv} !== {2'b11, ee, erd}) begin
                n_fail++;
                $display("FAIL rr_resp[%0d] got k%0d %b/%b/%h exp k%0d",
                         n, k, got, e, rdv, ek);
            end
            n_chk++;
            if (br !== exp_br(cw, ca, cd)) begin
                n_fail++;
                $display("FAIL rr_bridge[%0d] got %h exp %h",
                         n, br, exp_br(cw, ca, cd));
            end
            n_chk++;
            if ({stab, gap, oth, aw == 1} !== 4'b1101) begin
                n_fail++;
                $display("FAIL rr_proto[%0d] got %b exp 1101",
                         n, {stab, gap, oth, aw == 1});
            end
        end
    endtask

    task automatic test_timeout();
        v0 = 0; v1 = 1; w1 = 0; a1 = 9'h1F0; d1 = 8'h00;
        p_wait = 0; p_err_at = 0; p_hang = 1; p_data = 8'h99;
        do_txn(0);
        p_hang = 0;
        last_g = 1;
        n_chk++;
        if ({win == 1, k == TMO} !== 2'b11) begin
            n_fail++;
            $display("FAIL tmo_k got win%0d k%0d exp win1 k%0d",
                     win, k, TMO);
        end
        n_chk++;
        if ({got, e, rdv} !== {2'b11, 8'h00}) begin
            n_fail++;
            $display("FAIL tmo_resp got %b/%b/%h exp 1/1/00",
                     got, e, rdv);
        end
        n_chk++;
        if ({stab, gap, oth} !== 3'b110) begin
            n_fail++;
            $display("FAIL tmo_proto got %b exp 110", {stab, gap, oth});
        end
    endtask

    task automatic test_slverr();
        int ew;
        ew = rr_pick(1, 1, last_g);
        v0 = 1; v1 = 1;
        w0 = (ew == 1); a0 = 9'h044; d0 = 8'h5A;
        w1 = (ew == 0); a1 = 9'h1AA; d1 = 8'h5A;
        p_wait = 1; p_err_at = 2; p_hang = 0; p_data = 8'hC3;
        do_txn(0);
        last_g = ew;
        n_chk++;
        if ({win == ew, k == 2, got, e, rdv} !== {4'b1111, 8'h00}) begin
            n_fail++;
            $display("FAIL err_resp got w%0d k%0d %b/%b/%h exp w%0d k2",
                     win, k, got, e, rdv, ew);
        end
        p_err_at = 0;
        do_txn(0);
        n_chk++;
        if ({win == 1 - ew, k == 3, got, e, rdv}
            !== {4'b1110, 8'h00}) begin
            n_fail++;
            $display("FAIL err_next got w%0d k%0d %b/%b/%h exp w%0d k3",
                     win, k, got, e, rdv, 1 - ew);
        end
        n_chk++;
        if (br !== exp_br(1, (ew == 0) ? 9'h1AA : 9'h044, 8'h5A)) begin
            n_fail++; $display("FAIL err_next_bridge got %h", br);
        end
        last_g = 1 - ew;
    endtask

    task automatic test_reset_mid();
        bit acc, any;
        v0 = 1; w0 = 1; a0 = 9'h033; d0 = 8'h11; v1 = 0;
        p_wait = 0; p_err_at = 0; p_hang = 1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (r0) begin
                acc = 1; break;
            end
        end
        n_chk++;
        if (acc !== 1'b1) begin
            n_fail++; $display("FAIL rstm_accept got 0 exp 1");
        end
        v0 = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        n_chk++;
        if ({tr, rv0, rv1, rw, wpa, rpa, wdo} !== '0) begin
            n_fail++;
            $display("FAIL rstm_outs got %h exp 0",
                     {tr, rv0, rv1, rw, wpa, rpa, wdo});
        end
        rst = 0; p_hang = 0; any = 0;
        repeat (6) begin
            @(negedge clk);
            if (rv0 || rv1 || tr) any = 1;
        end
        n_chk++;
        if (any !== 1'b0) begin
            n_fail++; $display("FAIL rstm_noresp got 1 exp 0");
        end
        last_g = 1;
        v0 = 1; w0 = 0; a0 = 9'h0AB; v1 = 1; w1 = 0; a1 = 9'h1AB;
        p_data = 8'h42;
        do_txn(0);
        last_g = 0;
        n_chk++;
        if ({win == 0, k == 2, got, e, rdv} !== {4'b1110, 8'h42}) begin
            n_fail++;
            $display("FAIL rstm_tie got w%0d k%0d %b/%b/%h exp w0 k2 42",
                     win, k, got, e, rdv);
        end
    endtask

    task automatic test_random();
        int ek, ew; bit ee; logic [7:0] erd;
        bit cw; logic [8:0] ca; logic [7:0] cd;
        for (int n = 0; n < 40; n++) begin
            if (!v0 && !v1) begin
                if ($urandom_range(0, 1) == 0) begin
                    v0 = 1; w0 = 1'($urandom);
                    a0 = 9'($urandom); d0 = 8'($urandom);
                end else begin
                    v1 = 1; w1 = 1'($urandom);
                    a1 = 9'($urandom); d1 = 8'($urandom);
                end
            end
            p_wait   = $urandom_range(0, 3);
            p_err_at = ($urandom_range(0, 4) == 0) ?
                       $urandom_range(1, 4) : 0;
            p_hang   = ($urandom_range(0, 7) == 0);
            p_data   = 8'($urandom);
            ew = rr_pick(v0, v1, last_g);
            cw = ew ? w1 : w0; ca = ew ? a1 : a0; cd = ew ? d1 : d0;
            ref_txn(cw, p_wait, p_err_at, p_hang, p_data, ek, ee, erd);
            do_txn(1'($urandom));
            last_g = ew;
            n_chk++;
            if ({win == ew, k == ek} !== 2'b11) begin
                n_fail++;
                $display("FAIL rnd_grant[%0d] got w%0d k%0d exp w%0d k%0d",
                         n, win, k, ew, ek);
            end
            n_chk++;
            if ({got, e, rdv} !== {1'b1, ee, erd}) begin
                n_fail++;
                $display("FAIL rnd_resp[%0d] got %b/%b/%h exp 1/%b/%h",
                         n, got, e, rdv, ee, erd);
            end
            n_chk++;
            if (br !== exp_br(cw, ca, cd)) begin
                n_fail++;
                $display("FAIL rnd_bridge[%0d] got %h exp %h",
                         n, br, exp_br(cw, ca, cd));
            end
            n_chk++;
            if ({stab, gap, oth, aw == 1} !== 4'b1101) begin
                n_fail++;
                $display("FAIL rnd_proto[%0d] got %b exp 1101",
                         n, {stab, gap, oth, aw == 1});
            end
        end
    endtask

    initial begin
        rst = 1;
        v0 = 0; w0 = 0; a0 = '0; d0 = '0;
        v1 = 0; w1 = 0; a1 = '0; d1 = '0;
        pen = 0; prdy = 0; perr = 0; prd = '0;
        p_wait = 0; p_err_at = 0; p_hang = 0; p_data = '0;
        last_g = 1;
        test_reset();
        test_write();
        test_read_wait();
        test_rr_tie();
        test_timeout();
        test_slverr();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
